// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   OP_W      : width of the pc_unit op field
//   pc_op_e   : op encodings (5..7 are reserved and behave as hold)
package pc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    PC_OP_SEQ  = 3'd0,
    PC_OP_BR   = 3'd1,
    PC_OP_JMP  = 3'd2,
    PC_OP_CALL = 3'd3,
    PC_OP_RET  = 3'd4
  } pc_op_e;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, rst_n : clock, async active-low reset (clears count/pointer only)
//   push       : write push_data on top; when full the oldest entry is
//                overwritten and the count saturates at DEPTH
//   pop        : drop the top entry (ignored when empty)
//   push_data  : address to push
//   top_data   : current top-of-stack entry (valid when !empty)
//   empty/full : count == 0 / count == DEPTH
// DEPTH must be a power of two so the pointer wraps naturally.
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d, top_idx;
  logic [CW-1:0]               cnt_q, cnt_d;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign top_idx  = wr_ptr_q - PW'(1);
  assign top_data = mem_q[top_idx];

  // wr_ptr points at the next free slot; once full it points at the oldest
  // entry, so a push there is exactly the overwrite-oldest behaviour.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (!full) cnt_d = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      wr_ptr_d = wr_ptr_q - PW'(1);
      cnt_d    = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while count > 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with branch/jump/call/return.
//   clk, rst_n   : clock, async active-low reset (pc <- RESET_PC)
//   en           : advance enable; low holds pc, stack and flags
//   op           : SEQ/BR/JMP/CALL/RET (pc_pkg), 5..7 hold
//   decr, diff   : BR direction and unsigned magnitude
//   target       : JMP/CALL destination
//   err_clr      : clears sticky ras_ovf/ras_unf (independent of en)
//   pc, pc_plus1 : registered PC and PC+1
//   ras_empty/full/ovf/unf : stack status and sticky error flags
// Build option: define PC_RAS_EN to include the return-address stack.
// Without it CALL acts as JMP, RET as SEQ, and status outputs are constant.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter int                DISP_W    = 10,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [OP_W-1:0]   op,
  input  logic              decr,
  input  logic [DISP_W-1:0] diff,
  input  logic [ADDR_W-1:0] target,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc, br_off, br_sum;

  // All arithmetic wraps modulo 2^ADDR_W by construction.
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign br_off   = ADDR_W'(diff);
  assign br_sum   = decr ? (pc_q - br_off) : (pc_q + br_off);
  assign pc       = pc_q;
  assign pc_plus1 = pc_inc;

`ifdef PC_RAS_EN
  logic              ras_push, ras_pop, ret_unf;
  logic              st_empty, st_full;
  logic [ADDR_W-1:0] ras_top;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  assign ras_push = en && (op == PC_OP_CALL);
  assign ret_unf  = en && (op == PC_OP_RET) && st_empty;
  assign ras_pop  = en && (op == PC_OP_RET) && !st_empty;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .empty     (st_empty),
    .full      (st_full)
  );

  // Setting event beats a same-cycle clear.
  always_comb begin
    ovf_d = (ovf_q && !err_clr) || (ras_push && st_full);
    unf_d = (unf_q && !err_clr) || ret_unf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ras_empty = st_empty;
  assign ras_full  = st_full;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ras_empty      = 1'b1;
  assign ras_full       = 1'b0;
  assign ras_ovf        = 1'b0;
  assign ras_unf        = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
    if (en) begin
      case (op)
        PC_OP_SEQ:             pc_d = pc_inc;
        PC_OP_BR:              pc_d = br_sum;
        PC_OP_JMP, PC_OP_CALL: pc_d = target;
`ifdef PC_RAS_EN
        PC_OP_RET:             pc_d = st_empty ? pc_inc : ras_top;
`else
        PC_OP_RET:             pc_d = pc_inc;
`endif
        default:               pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  import pc_pkg::*;

  localparam int          AW    = 10;
  localparam int          DW    = 10;
  localparam int          DEPTH = 4;
  localparam logic [9:0]  RPC   = 10'h010;
  localparam int          MASK  = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, en, decr, err_clr;
  logic [2:0]    op;
  logic [DW-1:0] diff;
  logic [AW-1:0] target;
  logic [AW-1:0] pc, pc_plus1;
  logic          ras_empty, ras_full, ras_ovf, ras_unf;

  pc_unit #(.ADDR_W(AW), .DISP_W(DW), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .decr(decr), .diff(diff),
    .target(target), .err_clr(err_clr), .pc(pc), .pc_plus1(pc_plus1),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: PC as an integer, stack as a queue (newest at back).
  int m_pc;
  int stk[$];
  bit m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = int'(RPC);
    stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step(input bit e, input int o, input bit dc, input int df,
                            input int tg, input bit ec);
    bit set_ovf = 0, set_unf = 0;
    if (e) begin
      case (o)
        0: m_pc = (m_pc + 1) & MASK;
        1: m_pc = dc ? ((m_pc - df) & MASK) : ((m_pc + df) & MASK);
        2: m_pc = tg;
        3: begin
`ifdef PC_RAS_EN
          if (stk.size() == DEPTH) begin
            set_ovf = 1;
            void'(stk.pop_front());
          end
          stk.push_back((m_pc + 1) & MASK);
`endif
          m_pc = tg;
        end
        4: begin
`ifdef PC_RAS_EN
          if (stk.size() == 0) begin
            set_unf = 1;
            m_pc = (m_pc + 1) & MASK;
          end else m_pc = stk.pop_back();
`else
          m_pc = (m_pc + 1) & MASK;
`endif
        end
        default: ;
      endcase
    end
`ifdef PC_RAS_EN
    m_ovf = (m_ovf && !ec) || set_ovf;
    m_unf = (m_unf && !ec) || set_unf;
`endif
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    32'(pc),       32'(m_pc));
    chk({tag, ".pc1"},   32'(pc_plus1), 32'((m_pc + 1) & MASK));
`ifdef PC_RAS_EN
    chk({tag, ".empty"}, 32'(ras_empty), 32'(stk.size() == 0));
    chk({tag, ".full"},  32'(ras_full),  32'(stk.size() == DEPTH));
`else
    chk({tag, ".empty"}, 32'(ras_empty), 32'(1));
    chk({tag, ".full"},  32'(ras_full),  32'(0));
`endif
    chk({tag, ".ovf"},   32'(ras_ovf),  32'(m_ovf));
    chk({tag, ".unf"},   32'(ras_unf),  32'(m_unf));
  endtask

  // Drive one cycle of inputs, clock it, update model, check after the edge.
  task automatic step(input string tag, input bit e, input int o, input bit dc,
                      input int df, input int tg, input bit ec);
    logic [31:0] dv, tv;
    dv = df; tv = tg;
    en = e; op = o[2:0]; decr = dc; diff = dv[DW-1:0]; target = tv[AW-1:0]; err_clr = ec;
    @(posedge clk);
    model_step(e, o, dc, df & MASK, tg & MASK, ec);
    #1 check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; en = 0; op = '0; decr = 0; diff = '0; target = '0; err_clr = 0;
    model_reset();
    #12 check_all("reset");
    chk("reset.pc_lit", 32'(pc), 32'h010);
    #2 rst_n = 1'b1;

    // Sequential advance and hold
    step("seq1", 1, 0, 0, 0, 0, 0);
    step("seq2", 1, 0, 0, 0, 0, 0);
    step("seq3", 1, 0, 0, 0, 0, 0);
    chk("seq3.lit", 32'(pc), 32'h013);
    step("hold", 0, 0, 0, 0, 0, 0);
    chk("hold.lit", 32'(pc), 32'h013);

    // Wrap-around on SEQ and BR
    step("jmp3fe", 1, 2, 0, 0, 'h3FE, 0);
    step("wrap1",  1, 0, 0, 0, 0, 0);
    step("wrap2",  1, 0, 0, 0, 0, 0);
    chk("wrap.lit", 32'(pc), 32'h000);
    step("seq_to1", 1, 0, 0, 0, 0, 0);
    step("br_dec", 1, 1, 1, 3, 0, 0);
    chk("br_dec.lit", 32'(pc), 32'h3FE);
    step("br_inc", 1, 1, 0, 'h10, 0, 0);
    chk("br_inc.lit", 32'(pc), 32'h00E);

    // Nested call/return
    step("jmp20", 1, 2, 0, 0, 'h020, 0);
    step("call1", 1, 3, 0, 0, 'h100, 0);
    step("call2", 1, 3, 0, 0, 'h200, 0);
    step("ret1",  1, 4, 0, 0, 0, 0);
    step("ret2",  1, 4, 0, 0, 0, 0);
`ifdef PC_RAS_EN
    chk("ret2.lit", 32'(pc), 32'h021);
`endif

    // Overflow / underflow
    step("jmp0", 1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("ovf_call", 1, 3, 0, 0, 'h040 * (i + 1), 0);
    for (int i = 0; i < 5; i++) step("unf_ret", 1, 4, 0, 0, 0, 0);
    step("clr_en0", 0, 4, 0, 0, 0, 1);
    step("clr_vs_set", 1, 4, 0, 0, 0, 1);
    step("reserved", 1, 6, 0, 0, 'h123, 0);
    step("en0_call", 0, 3, 0, 0, 'h155, 0);

    // Asynchronous reset mid-cycle after two calls
    step("pre_c1", 1, 3, 0, 0, 'h0AA, 0);
    step("pre_c2", 1, 3, 0, 0, 'h0BB, 0);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_all("midrst");
    #2 rst_n = 1'b1;
    step("ret_after_rst", 1, 4, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 9) != 0), $urandom_range(0, 7),
           1'($urandom_range(0, 1)), int'($urandom_range(0, MASK)),
           int'($urandom_range(0, MASK)), ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
